// File: rtl/ctrl_pipe_unit_if.sv
// Control-pipe bus: ID-stage inputs, squash request, and the EX/MEM/WB
// control bundle handed to the datapath.
interface ctrl_pipe_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  flush;
    logic                  stall;
    logic                  id_illegal;
    logic                  ex_valid;
    logic                  ex_alu_src;
    logic                  ex_branch;
    logic                  ex_jump;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] wb_rd;

    // Front end / datapath side
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        input  stall, id_illegal,
        input  ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_rd,
        input  mem_valid, mem_read, mem_write, mem_rd,
        input  wb_valid, wb_reg_write, wb_sel, wb_rd
    );

    // Control unit side
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        output stall, id_illegal,
        output ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_rd,
        output mem_valid, mem_read, mem_write, mem_rd,
        output wb_valid, wb_reg_write, wb_sel, wb_rd
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: RV32I opcode decode in ID plus the ID/EX, EX/MEM and
// MEM/WB control registers, with load-use stall and branch squash.
// Optional macro CTRL_PERF_CNT_EN adds saturating stall/flush counters.
module ctrl_pipe_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_pipe_unit_if.slave   bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // One stage worth of control; an all-zero value is a bubble, so every
    // stage output is valid-qualified for free.
    typedef struct packed {
        logic                  reg_write;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic [1:0]            wb_sel;
        logic                  branch;
        logic                  jump;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    ctrl_t       dec;
    logic        legal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    ctrl_t       ex_q, mem_q, wb_q;
    logic [3:1]  vld_pipe;   // [1]=EX, [2]=MEM, [3]=WB

    // Opcode decode into the control bundle plus source-use flags
    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (bus.id_opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_W'(2'b10);
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_W'(2'b11);
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.wb_sel    = 2'b01;
                uses_rs1      = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BR: begin
                dec.branch    = 1'b1;
                dec.alu_op    = ALU_OP_W'(2'b01);
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.jump      = 1'b1;
                uses_rs1      = (bus.id_opcode == OP_JALR);
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Writes to x0 are dropped here so later stages never see them
        if (bus.id_rd == '0) dec.reg_write = 1'b0;
        dec.rd = bus.id_rd;
    end

    // Load-use hazard against the instruction currently in EX
    always_comb begin
        hazard = bus.id_valid & vld_pipe[1] & ex_q.mem_read & (ex_q.rd != '0) &
                 ((uses_rs1 & (bus.id_rs1 == ex_q.rd)) |
                  (uses_rs2 & (bus.id_rs2 == ex_q.rd)));
    end

    assign bus.stall      = hazard;
    assign bus.id_illegal = bus.id_valid & ~legal;

    // Pipeline registers: ID/EX takes a bubble on any squash condition,
    // EX/MEM and MEM/WB always advance; reset clears every stage at once
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            vld_pipe <= '0;
        end else begin
            if (bus.flush || hazard || !bus.id_valid || !legal) begin
                ex_q        <= '0;
                vld_pipe[1] <= 1'b0;
            end else begin
                ex_q        <= dec;
                vld_pipe[1] <= 1'b1;
            end
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            vld_pipe[3:2] <= vld_pipe[2:1];
        end
    end

    assign bus.ex_valid     = vld_pipe[1];
    assign bus.ex_alu_src   = ex_q.alu_src;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.mem_valid    = vld_pipe[2];
    assign bus.mem_read     = mem_q.mem_read;
    assign bus.mem_write    = mem_q.mem_write;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.wb_valid     = vld_pipe[3];
    assign bus.wb_reg_write = wb_q.reg_write;
    assign bus.wb_sel       = wb_q.wb_sel;
    assign bus.wb_rd        = wb_q.rd;

`ifdef CTRL_PERF_CNT_EN
    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: directed test-plan sequences followed by random
// traffic, all checked against a history-based reference model.
module tb_ctrl_pipe_unit;
    localparam int RW = 5;
    localparam int AW = 2;
`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int exp_scnt, exp_fcnt;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.REG_ADDR_W(RW), .ALU_OP_W(AW)) bus ();

`ifdef CTRL_PERF_CNT_EN
    ctrl_pipe_unit #(.REG_ADDR_W(RW), .ALU_OP_W(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    ctrl_pipe_unit #(.REG_ADDR_W(RW), .ALU_OP_W(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`endif

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] BAD = 7'b1111111;

    // What entered EX on a given edge; zero means bubble
    typedef struct packed {
        logic v, rw, as, mr, mw;
        logic [1:0] ws;
        logic br, j;
        logic [1:0] aop;
        logic [4:0] rd;
    } bnd_t;

    bnd_t hist[$];
    logic rsth[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, hist.size());
    endtask

    // Table: {legal, reg_write, alu_src, mem_read, mem_write, wb_sel, branch, jump, alu_op}
    function automatic logic [10:0] ref_dec(input logic [6:0] op);
        case (op)
            R:           return 11'b1_1000_00_00_10;
            I:           return 11'b1_1100_00_00_11;
            LD:          return 11'b1_1110_01_00_00;
            ST:          return 11'b1_0101_00_00_00;
            BR:          return 11'b1_0000_00_10_01;
            JAL, JALR:   return 11'b1_1100_10_01_00;
            LUI, AUIPC:  return 11'b1_1100_00_00_00;
            default:     return 11'b0;
        endcase
    endfunction

    // Expected contents of stage s (0 EX, 1 MEM, 2 WB) after the latest edge
    function automatic bnd_t stage_exp(input int s);
        int k = hist.size() - 1;
        if (k - s < 0) return '0;
        for (int i = k - s + 1; i <= k; i++) if (rsth[i]) return '0;
        return hist[k - s];
    endfunction

    // One clock: drive ID, check comb outputs, then check all stages after the edge
    task automatic step(input logic r, input logic v, input logic [6:0] op,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic f);
        logic [10:0] dv;
        logic u1, u2, es, ei;
        bnd_t exb, e, got;
        @(negedge clk);
        rst = r; bus.id_valid = v; bus.id_opcode = op;
        bus.id_rs1 = a; bus.id_rs2 = b; bus.id_rd = d; bus.flush = f;
        #1;
        dv  = ref_dec(op);
        u1  = (op inside {R, I, LD, ST, BR, JALR});
        u2  = (op inside {R, ST, BR});
        exb = stage_exp(0);
        es  = v & exb.v & exb.mr & (exb.rd != 0) & ((u1 & a == exb.rd) | (u2 & b == exb.rd));
        ei  = v & ~dv[10];
        if (hist.size() > 0) begin
            chk("stall", 32'(bus.stall), 32'(es));
            chk("id_illegal", 32'(bus.id_illegal), 32'(ei));
        end
        if (r || f || es || !v || !dv[10]) e = '0;
        else begin
            e = {1'b1, dv[9:0], d};
            if (d == 0) e.rw = 1'b0;
        end
        hist.push_back(e);
        rsth.push_back(r);
`ifdef CTRL_PERF_CNT_EN
        if (r) begin exp_scnt = 0; exp_fcnt = 0; end
        else begin
            if (es && exp_scnt < 15) exp_scnt++;
            if (f && exp_fcnt < 15) exp_fcnt++;
        end
`endif
        @(posedge clk);
        #1;
        e = stage_exp(0);
        chk("ex", {bus.ex_valid, bus.ex_alu_src, bus.ex_branch, bus.ex_jump, bus.ex_alu_op, bus.ex_rd},
                  {e.v, e.as, e.br, e.j, e.aop, e.rd});
        e = stage_exp(1);
        chk("mem", {bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_rd},
                   {e.v, e.mr, e.mw, e.rd});
        e = stage_exp(2);
        chk("wb", {bus.wb_valid, bus.wb_reg_write, bus.wb_sel, bus.wb_rd},
                  {e.v, e.rw, e.ws, e.rd});
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(exp_fcnt));
`endif
        got = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 7'd0, 0, 0, 0, 0);
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, BAD};
        bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1 = 0;
        bus.id_rs2 = 0; bus.id_rd = 0; bus.flush = 0;
`ifdef CTRL_PERF_CNT_EN
        exp_scnt = 0; exp_fcnt = 0;
`endif
        // Reset with a valid R instruction pending, then add x3
        step(1, 1, R, 1, 2, 3, 0);
        step(1, 1, R, 1, 2, 3, 0);
        step(0, 1, R, 1, 2, 3, 0);
        idle(3);
        // Load-use: lw x5 then add x6,x5,x1 (held for the stall)
        step(0, 1, LD, 1, 0, 5, 0);
        step(0, 1, R, 5, 1, 6, 0);
        step(0, 1, R, 5, 1, 6, 0);
        idle(3);
        // Same with rd = x0
        step(0, 1, LD, 1, 0, 0, 0);
        step(0, 1, R, 0, 1, 6, 0);
        // Non-hazard sources
        step(0, 1, LD, 1, 0, 5, 0);
        step(0, 1, ST, 2, 7, 0, 0);
        step(0, 1, LD, 1, 0, 5, 0);
        step(0, 1, JAL, 5, 5, 1, 0);
        idle(3);
        // Flush on a store, then flush together with a load-use stall
        step(0, 1, ST, 2, 7, 4, 1);
        step(0, 1, LD, 1, 0, 5, 0);
        step(0, 1, R, 5, 5, 6, 1);
        idle(3);
        // Decode sweep including an illegal opcode
        for (int i = 0; i < 10; i++) step(0, 1, ops[i], 1, 2, 5'(i + 8), 0);
        idle(3);
        // Five stalls in a row and two flushes
        for (int i = 0; i < 5; i++) begin
            step(0, 1, LD, 1, 0, 9, 0);
            step(0, 1, BR, 9, 3, 0, 0);
        end
        step(0, 1, I, 1, 0, 2, 1);
        step(0, 1, I, 1, 0, 2, 1);
        // Twenty back-to-back stalls to reach counter saturation
        for (int i = 0; i < 20; i++) begin
            step(0, 1, LD, 1, 0, 9, 0);
            step(0, 1, R, 9, 9, 0, 0);
        end
        // Random traffic biased toward hazards
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            logic [4:0] a, b, d;
            logic r, v, f;
            int sel = $urandom_range(0, 12);
            op = (sel >= 10) ? LD : ops[sel];
            if (sel == 9) op = 7'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            b = 5'($urandom_range(0, 3));
            d = 5'($urandom_range(0, 3));
            v = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 63) == 0);
            step(r, v, op, a, b, d, f);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
